// File: rtl/mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : mem_arbiter                                                |
// | Description : Two-requester (icache / dcache) arbiter for the single     |
// |               main-memory port. Grants one owner per transaction,        |
// |               latches its request, issues a one-cycle pulse to memory,   |
// |               routes the response back and hands over back-to-back.      |
// |               Optional: define MEM_ARB_ROUND_ROBIN_EN for round-robin    |
// |               selection in IDLE (default: dcache has fixed priority).    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int LINE_W         = 128,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req_valid,
  input  logic              i_req_rw,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [LINE_W-1:0] i_req_data,
  output logic              i_grant,
  output logic              i_resp_valid,
  output logic [LINE_W-1:0] i_resp_data,
  input  logic              d_req_valid,
  input  logic              d_req_rw,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [LINE_W-1:0] d_req_data,
  output logic              d_grant,
  output logic              d_resp_valid,
  output logic [LINE_W-1:0] d_resp_data,
  output logic              mem_req_valid,
  output logic              mem_req_rw,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [LINE_W-1:0] mem_req_data,
  input  logic              mem_resp_valid,
  input  logic [LINE_W-1:0] mem_resp_data,
  output logic              err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 2);
  localparam bit WDOG_EN = (TIMEOUT_CYCLES > 0);
  // Last busy-cycle count at which a missing response triggers the abort.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                pulse_q, pulse_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                grant_new;
  logic                grant_to_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic                rr_q, rr_d;   // 1 = dcache side has priority
`endif

  // Next-state, winner selection, request latching and watchdog.
  always_comb begin
    state_d    = state_q;
    pulse_d    = 1'b0;
    rw_d       = rw_q;
    addr_d     = addr_q;
    data_d     = data_q;
    cnt_d      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    err_d      = err_q;
    grant_new  = 1'b0;
    grant_to_d = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    rr_d       = rr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (i_req_valid || d_req_valid) begin
          grant_new = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          grant_to_d = (i_req_valid && d_req_valid) ? rr_q : d_req_valid;
`else
          grant_to_d = d_req_valid;
`endif
        end
      end
      BUSY_I: begin
        // Owner is excluded: only the dcache can take over on handover.
        if (mem_resp_valid) begin
          if (d_req_valid) begin
            grant_new  = 1'b1;
            grant_to_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (WDOG_EN && (cnt_q == CNT_LAST)) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      BUSY_D: begin
        if (mem_resp_valid) begin
          if (i_req_valid) begin
            grant_new  = 1'b1;
            grant_to_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else if (WDOG_EN && (cnt_q == CNT_LAST)) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant_new) begin
      state_d = grant_to_d ? BUSY_D : BUSY_I;
      pulse_d = 1'b1;
      cnt_d   = '0;
      rw_d    = grant_to_d ? d_req_rw   : i_req_rw;
      addr_d  = grant_to_d ? d_req_addr : i_req_addr;
      data_d  = grant_to_d ? d_req_data : i_req_data;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_d    = ~grant_to_d;
`endif
    end
  end

  // State and latched-request registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pulse_q <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pulse_q <= pulse_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_q    <= rr_d;
`endif
    end
  end

  assign i_grant       = (state_q == BUSY_I);
  assign d_grant       = (state_q == BUSY_D);
  assign i_resp_valid  = i_grant & mem_resp_valid;
  assign d_resp_valid  = d_grant & mem_resp_valid;
  assign i_resp_data   = i_resp_valid ? mem_resp_data : '0;
  assign d_resp_data   = d_resp_valid ? mem_resp_data : '0;
  assign mem_req_valid = pulse_q;
  assign mem_req_rw    = rw_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_data  = data_q;
  assign err_timeout   = err_q;

endmodule
`default_nettype wire
